axil_seq_wr_rd_checker: RTL

- Synthesizable AXI4-Lite master that generalises the sequential write/read-back register check into hardware.
- Writes N generated data words to consecutive slave registers, reads them back, and compares each word.
- Checks every response code and flags mismatches, error responses and timeouts.
- Sits beside an AXI4-Lite peripheral (e.g. the text-LCD register slave) for bring-up and on-board self-test without a BFM.

---
 rtl/axil_seq_pkg.sv | 20 ++
 rtl/axil_seq_pattern.sv | 21 ++
 rtl/axil_seq_wr_rd_checker.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/axil_seq_pkg.sv
// Shared types and constants for the AXI4-Lite sequential write/read-back checker.
package axil_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WADDR  = 3'd1,
    S_WRESP  = 3'd2,
    S_RADDR  = 3'd3,
    S_RDATA  = 3'd4,
    S_NEXT   = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int ERR_CNT_W = 9;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/axil_seq_pattern.sv
// Test-pattern generator: word i is SEED+i, optionally inverted.
// The same instance feeds WDATA and the read-back compare, so both paths
// always agree on what register i should hold.
module axil_seq_pattern #(
  parameter int          DATA_W = 32,
  parameter logic [31:0] SEED   = 32'h0101_FFFF
) (
  input  logic [7:0]        i_idx,
  input  logic              i_inv,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_seed;
  logic [DATA_W-1:0] w_sum;

  // Seed is zero-extended or truncated to the bus width.
  assign w_seed = DATA_W'(SEED);
  assign w_sum  = w_seed + DATA_W'(i_idx);
  assign o_data = i_inv ? ~w_sum : w_sum;

endmodule

// File: rtl/axil_seq_wr_rd_checker.sv
// AXI4-Lite master that writes N pattern words to consecutive registers,
// reads them back and reports mismatches, non-OKAY responses and timeouts.
//
// Handshake rule on every channel: a transfer happens on a rising ACLK edge
// where VALID and READY are both high; this master never drops a VALID it
// has raised until that edge (except when a timeout aborts the run), and its
// VALID/READY outputs depend only on registered state.
module axil_seq_wr_rd_checker
  import axil_seq_pkg::*;
#(
  parameter int                          C_M_AXI_ADDR_WIDTH = 32,
  parameter int                          C_M_AXI_DATA_WIDTH = 32,
  parameter int                          NUM_TRANSACTIONS   = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR        = '0,
  parameter int                          ADDR_STRIDE        = C_M_AXI_DATA_WIDTH / 8,
  parameter logic [31:0]                 SEED               = 32'h0101_FFFF,
  parameter int                          TIMEOUT_CYCLES     = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic                            interleave,
  input  logic                            pattern_inv,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic                            timeout,
  output logic [ERR_CNT_W-1:0]            err_count,
  output logic [7:0]                      first_err_idx,
  output state_t                          dbg_state,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int ADDR_W = C_M_AXI_ADDR_WIDTH;
  localparam int DATA_W = C_M_AXI_DATA_WIDTH;
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        LAST_IDX = 8'(NUM_TRANSACTIONS - 1);

  state_t              r_state, w_state_n;
  logic [7:0]          r_idx;
  logic                r_rphase, r_inter, r_inv;
  logic                r_aw_done, r_w_done;
  logic [TCNT_W-1:0]   r_tcnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_error, r_timeout;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [7:0]          r_first_idx;

  logic [DATA_W-1:0]   w_pat;
  logic                w_aw_hs, w_w_hs, w_tmo, w_last;
  logic                w_wait_state, w_err_evt, w_tmo_evt;

  axil_seq_pattern #(.DATA_W(DATA_W), .SEED(SEED)) u_pattern (
    .i_idx  (r_idx),
    .i_inv  (r_inv),
    .o_data (w_pat)
  );

  assign M_AXI_AWVALID = (r_state == S_WADDR) && !r_aw_done;
  assign M_AXI_WVALID  = (r_state == S_WADDR) && !r_w_done;
  assign M_AXI_BREADY  = (r_state == S_WRESP);
  assign M_AXI_ARVALID = (r_state == S_RADDR);
  assign M_AXI_RREADY  = (r_state == S_RDATA);
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_WDATA   = w_pat;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;

  assign w_aw_hs      = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_w_hs       = M_AXI_WVALID && M_AXI_WREADY;
  assign w_tmo        = (r_tcnt == TMO_LAST);
  assign w_last       = (r_idx == LAST_IDX);
  assign w_wait_state = (r_state == S_WADDR) || (r_state == S_WRESP) ||
                        (r_state == S_RADDR) || (r_state == S_RDATA);
  // At most one error per beat: a bad response code masks the data compare.
  assign w_err_evt = ((r_state == S_WRESP) && M_AXI_BVALID && (M_AXI_BRESP != RESP_OKAY)) ||
                     ((r_state == S_RDATA) && M_AXI_RVALID &&
                      ((M_AXI_RRESP != RESP_OKAY) || (M_AXI_RDATA != w_pat)));
  // A wait state only jumps straight to FINISH when its timer expired.
  assign w_tmo_evt = w_wait_state && (w_state_n == S_FINISH);

  assign busy          = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done          = (r_state == S_FINISH);
  assign error         = r_error;
  assign timeout       = r_timeout;
  assign err_count     = r_err_cnt;
  assign first_err_idx = r_first_idx;
  assign dbg_state     = r_state;

  // Next-state logic; a completed handshake wins over a same-cycle timeout.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_n = S_WADDR;
      S_WADDR: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_n = S_WRESP;
        else if (w_tmo)                                      w_state_n = S_FINISH;
      end
      S_WRESP: begin
        if (M_AXI_BVALID) w_state_n = r_inter ? S_RADDR : S_NEXT;
        else if (w_tmo)   w_state_n = S_FINISH;
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) w_state_n = S_RDATA;
        else if (w_tmo)    w_state_n = S_FINISH;
      end
      S_RDATA: begin
        if (M_AXI_RVALID) w_state_n = S_NEXT;
        else if (w_tmo)   w_state_n = S_FINISH;
      end
      S_NEXT: begin
        if (r_inter)        w_state_n = w_last ? S_FINISH : S_WADDR;
        else if (!r_rphase) w_state_n = w_last ? S_RADDR  : S_WADDR;
        else                w_state_n = w_last ? S_FINISH : S_RADDR;
      end
      S_FINISH: w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= S_IDLE;
    else          r_state <= w_state_n;
  end

  // Per-state wait timer and per-channel AW/W completion flags.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_tcnt    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_state_n != r_state) r_tcnt <= '0;
      else                      r_tcnt <= r_tcnt + TCNT_W'(1);
      if ((w_state_n == S_WADDR) && (r_state != S_WADDR)) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
    end
  end

  // Run control: mode latches, register index, write/read phase, address.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_inter  <= 1'b0;
      r_inv    <= 1'b0;
      r_idx    <= '0;
      r_rphase <= 1'b0;
      r_addr   <= BASE_ADDR;
    end else if ((r_state == S_IDLE) && start) begin
      r_inter  <= interleave;
      r_inv    <= pattern_inv;
      r_idx    <= '0;
      r_rphase <= 1'b0;
      r_addr   <= BASE_ADDR;
    end else if (r_state == S_NEXT) begin
      if (!w_last) begin
        r_idx  <= r_idx + 8'd1;
        r_addr <= r_addr + ADDR_W'(ADDR_STRIDE);
      end else if (!r_inter && !r_rphase) begin
        r_idx    <= '0;
        r_rphase <= 1'b1;
        r_addr   <= BASE_ADDR;
      end
    end
  end

  // Sticky status: cleared by an accepted start, updated by error/timeout events.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_error     <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= '0;
      r_first_idx <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_error     <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= '0;
      r_first_idx <= '0;
    end else if (w_err_evt || w_tmo_evt) begin
      r_error <= 1'b1;
      if (!r_error) r_first_idx <= r_idx;
      if (w_tmo_evt) r_timeout <= 1'b1;
      else if (r_err_cnt != ERR_CNT_MAX) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule
